// File: rtl/alu_iter.sv
// Per-thread ALU: single-cycle ADD/SUB/MUL/CMP plus an iterative restoring
// divider (DIV/REM) behind a start/done handshake with enable-driven stall.
module alu_iter #(
    parameter  int DATA_WIDTH = 8,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  cmp_signed,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] alu_out
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_REM = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;

    typedef enum logic {IDLE, DIVIDE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   alu_out_q, alu_out_d;
    logic                    done_q, done_d;
    logic                    dbz_q, dbz_d;
    logic [DATA_WIDTH-1:0]   quot_q, quot_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   divisor_q, divisor_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    is_rem_q, is_rem_d;

    logic [DATA_WIDTH:0]     rem_shift;
    logic [DATA_WIDTH:0]     rem_sub;
    logic [DATA_WIDTH-1:0]   step_rem;
    logic [DATA_WIDTH-1:0]   step_quot;
    logic                    cmp_lt, cmp_eq, cmp_gt;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, quot_q[DATA_WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, divisor_q};
        if (!rem_sub[DATA_WIDTH]) begin
            step_rem  = rem_sub[DATA_WIDTH-1:0];
            step_quot = {quot_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            step_rem  = rem_shift[DATA_WIDTH-1:0];
            step_quot = {quot_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        cmp_eq = (rs == rt);
        if (cmp_signed) begin
            cmp_lt = ($signed(rs) < $signed(rt));
        end else begin
            cmp_lt = (rs < rt);
        end
        cmp_gt = !cmp_eq && !cmp_lt;
    end

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b0;
                        case (op)
                            OP_ADD: alu_out_d = rs + rt;
                            OP_SUB: alu_out_d = rs - rt;
                            OP_MUL: alu_out_d = rs * rt;
                            OP_DIV, OP_REM: begin
                                if (rt == '0) begin
                                    alu_out_d = (op == OP_DIV) ? '1 : rs;
                                    dbz_d     = 1'b1;
                                end else begin
                                    done_d    = 1'b0;
                                    dbz_d     = dbz_q;
                                    quot_d    = rs;
                                    rem_d     = '0;
                                    divisor_d = rt;
                                    cnt_d     = CNT_WIDTH'(DATA_WIDTH);
                                    is_rem_d  = (op == OP_REM);
                                    state_d   = DIVIDE;
                                end
                            end
                            OP_CMP: begin
                                alu_out_d      = '0;
                                alu_out_d[2:0] = {cmp_gt, cmp_eq, cmp_lt};
                            end
                            default: alu_out_d = '0;
                        endcase
                    end
                end
                DIVIDE: begin
                    quot_d = step_quot;
                    rem_d  = step_rem;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        alu_out_d = is_rem_q ? step_rem : step_quot;
                        done_d    = 1'b1;
                        dbz_d     = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            alu_out_q <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
        end
    end

    assign busy        = (state_q == DIVIDE);
    assign done        = done_q & enable;
    assign div_by_zero = dbz_q;
    assign alu_out     = alu_out_q;
endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: expectations queued at issue, checked on done.
module tb_alu_iter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic         cmp_signed = 1'b0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] alu_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
    } exp_t;
    exp_t sb[$];

    alu_iter #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .op(op),
        .cmp_signed(cmp_signed), .rs(rs), .rt(rt), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cs);
        exp_t e;
        byte sa, sb_;
        int  ua, ub;
        e.res = '0; e.dbz = 1'b0; e.lat = 0;
        ua = int'(a); ub = int'(b);
        sa = a; sb_ = b;
        case (o)
            3'd0: e.res = W'((ua + ub) % 256);
            3'd1: e.res = W'((ua - ub + 256) % 256);
            3'd2: e.res = W'((ua * ub) % 256);
            3'd3: if (ub == 0) begin e.res = 8'hFF; e.dbz = 1'b1; end
                  else begin e.res = W'(ua / ub); e.lat = W; end
            3'd4: if (ub == 0) begin e.res = a; e.dbz = 1'b1; end
                  else begin e.res = W'(ua % ub); e.lat = W; end
            3'd5: begin
                if (cs) e.res = (sa < sb_) ? 8'h01 : (sa == sb_) ? 8'h02 : 8'h04;
                else    e.res = (ua < ub)  ? 8'h01 : (ua == ub)  ? 8'h02 : 8'h04;
            end
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // Issue one op and wait for done; returns what the DUT showed, no judging.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cs, output logic [W-1:0] res, output logic dbz,
                          output int edges, output int bcyc, output logic bsy_at_done,
                          output logic to);
        op = o; rs = a; rt = b; cmp_signed = cs; start = 1'b1;
        sb.push_back(model(o, a, b, cs));
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0; bcyc = 0; to = 1'b0;
        while (done !== 1'b1) begin
            if (edges >= 40) begin to = 1'b1; break; end
            if (busy === 1'b1) bcyc++;
            @(posedge clk); #1;
            edges++;
        end
        res = alu_out; dbz = div_by_zero; bsy_at_done = busy;
        $display("op=%0d rs=%0d rt=%0d cs=%0d -> alu_out=%0d dbz=%0d edges=%0d",
                 o, a, b, cs, res, dbz, edges);
    endtask

    task automatic check_simple(input string name, input logic [2:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic cs);
        logic [W-1:0] res; logic dbz, bad, to; int edges, bcyc; exp_t e;
        run_op(o, a, b, cs, res, dbz, edges, bcyc, bad, to);
        e = sb.pop_front();
        checks++;
        if (to || res !== e.res) begin
            failures++;
            $display("FAIL %s result: got %0d timeout=%0d expected %0d", name, res, to, e.res);
        end
        checks++;
        if (dbz !== e.dbz || edges != e.lat) begin
            failures++;
            $display("FAIL %s dbz/latency: got dbz=%0d edges=%0d expected dbz=%0d edges=%0d",
                     name, dbz, edges, e.dbz, e.lat);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; #1;
        checks++;
        if ({alu_out, busy, done, div_by_zero} !== '0) begin
            failures++;
            $display("FAIL reset_state: got out=%0d busy=%0d done=%0d dbz=%0d expected all 0",
                     alu_out, busy, done, div_by_zero);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got done=%0d busy=%0d expected 0 0", done, busy);
        end
        $display("reset checked");
    endtask

    task automatic test_arith;
        check_simple("add_wrap", 3'd0, 8'd200, 8'd100, 1'b0);
        check_simple("mul_low", 3'd2, 8'd20, 8'd13, 1'b0);
        check_simple("sub_wrap", 3'd1, 8'd5, 8'd9, 1'b0);
        check_simple("reserved", 3'd6, 8'd5, 8'd9, 1'b0);
    endtask

    task automatic test_divide;
        logic [W-1:0] res; logic dbz, bsy, to; int edges, bcyc; exp_t e;
        logic [2:0] ops [2] = '{3'd3, 3'd4};
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], 8'd100, 8'd7, 1'b0, res, dbz, edges, bcyc, bsy, to);
            e = sb.pop_front();
            checks++;
            if (to || res !== e.res || dbz !== e.dbz) begin
                failures++;
                $display("FAIL div_result op=%0d: got %0d dbz=%0d expected %0d dbz=%0d",
                         ops[i], res, dbz, e.res, e.dbz);
            end
            checks++;
            if (edges != e.lat || bcyc != W || bsy !== 1'b0) begin
                failures++;
                $display("FAIL div_timing op=%0d: got edges=%0d busy_cycles=%0d busy_at_done=%0d expected %0d %0d 0",
                         ops[i], edges, bcyc, bsy, e.lat, W);
            end
        end
        check_simple("div_255_1", 3'd3, 8'd255, 8'd1, 1'b0);
        check_simple("rem_small", 3'd4, 8'd3, 8'd200, 1'b0);
    endtask

    task automatic test_div_zero;
        check_simple("div_zero", 3'd3, 8'd37, 8'd0, 1'b0);
        check_simple("rem_zero", 3'd4, 8'd37, 8'd0, 1'b0);
        check_simple("add_clears_dbz", 3'd0, 8'd1, 8'd2, 1'b0);
    endtask

    task automatic test_compare;
        check_simple("cmp_signed_lt", 3'd5, 8'hFE, 8'h01, 1'b1);
        check_simple("cmp_unsigned_gt", 3'd5, 8'hFE, 8'h01, 1'b0);
        check_simple("cmp_eq", 3'd5, 8'h33, 8'h33, 1'b0);
        check_simple("cmp_signed_gt", 3'd5, 8'h05, 8'h80, 1'b1);
    endtask

    task automatic test_stall;
        exp_t e;
        int edges;
        logic bad = 1'b0;
        op = 3'd3; rs = 8'd255; rt = 8'd16; start = 1'b1;
        sb.push_back(model(3'd3, 8'd255, 8'd16, 1'b0));
        @(posedge clk); #1;
        op = 3'd0; rs = 8'd1; rt = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        @(posedge clk); #1; edges++;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; edges++;
            if (done !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL stall_hold: done/busy not held at 0/1 during stall");
        end
        enable = 1'b1;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
        e = sb.pop_front();
        $display("stalled DIV 255/16 -> alu_out=%0d edges=%0d", alu_out, edges);
        checks++;
        if (done !== 1'b1 || alu_out !== e.res || edges != W + 3) begin
            failures++;
            $display("FAIL stall_div: got out=%0d edges=%0d done=%0d expected out=%0d edges=%0d",
                     alu_out, edges, done, e.res, W + 3);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_ignored_start: got done=%0d busy=%0d expected 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int edges;
        op = 3'd0; rs = 8'd3; rt = 8'd4; start = 1'b1;
        sb.push_back(model(3'd0, 8'd3, 8'd4, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || alu_out !== e.res) begin
            failures++;
            $display("FAIL b2b_add: got done=%0d out=%0d expected 1 %0d", done, alu_out, e.res);
        end
        op = 3'd1; rs = 8'd10; rt = 8'd3;
        sb.push_back(model(3'd1, 8'd10, 8'd3, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || alu_out !== e.res) begin
            failures++;
            $display("FAIL b2b_sub: got done=%0d out=%0d expected 1 %0d", done, alu_out, e.res);
        end
        op = 3'd3; rs = 8'd200; rt = 8'd10;
        sb.push_back(model(3'd3, 8'd200, 8'd10, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || alu_out !== e.res || edges != e.lat) begin
            failures++;
            $display("FAIL b2b_div: got out=%0d edges=%0d expected %0d %0d", alu_out, edges, e.res, e.lat);
        end
        op = 3'd0; rs = 8'd1; rt = 8'd2; start = 1'b1;
        sb.push_back(model(3'd0, 8'd1, 8'd2, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        e = sb.pop_front();
        $display("done+start overlap ADD 1+2 -> done=%0d alu_out=%0d", done, alu_out);
        checks++;
        if (done !== 1'b1 || alu_out !== e.res) begin
            failures++;
            $display("FAIL b2b_done_start: got done=%0d out=%0d expected 1 %0d", done, alu_out, e.res);
        end
    endtask

    task automatic test_async_reset;
        logic stale = 1'b0;
        check_simple("pre_reset_divzero", 3'd3, 8'd37, 8'd0, 1'b0);
        op = 3'd3; rs = 8'd100; rt = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({alu_out, busy, done, div_by_zero} !== '0) begin
            failures++;
            $display("FAIL async_reset: got out=%0d busy=%0d done=%0d dbz=%0d expected all 0",
                     alu_out, busy, done, div_by_zero);
        end
        @(posedge clk); #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            failures++;
            $display("FAIL no_stale_done: got done/busy after aborted division expected none");
        end
        check_simple("post_reset_add", 3'd0, 8'd1, 8'd1, 1'b0);
    endtask

    initial begin
        test_reset;
        test_arith;
        test_divide;
        test_div_zero;
        test_compare;
        test_stall;
        test_back_to_back;
        test_async_reset;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
